// File: rtl/dac_spi_tx.sv
// SPI transmitter for an MCP49x1-style DAC: one 16-bit write frame per accepted sample.
// Optional DAC_SPI_LDAC_EN adds a post-frame LDAC strobe; otherwise dac_ldac_n is tied low.
module dac_spi_tx #(
  parameter int          DAC_N    = 10,
  parameter int          CLK_DIV  = 4,
  parameter logic [3:0]  CFG_BITS = 4'b0111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DAC_N-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  output logic             dac_ldac_n,
  output logic             busy
);

  // state    | meaning
  // IDLE     | cs_n high, waiting for a sample
  // CS_SETUP | cs_n low, first bit on mosi, one half-period
  // SHIFT    | 16 bits, two half-periods each (sclk low, then high)
  // CS_HOLD  | cs_n low one half-period, then cs_n high one half-period
  // LDAC     | dac_ldac_n low one half-period (DAC_SPI_LDAC_EN only)
  // GAP      | cs_n high one half-period before returning to IDLE
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
`ifdef DAC_SPI_LDAC_EN
    LDAC     = 3'd4,
`endif
    GAP      = 3'd5
  } state_t;

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int             PAD      = 12 - DAC_N;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       bit_q;
  logic             phase_q;
  logic [15:0]      sreg_q;
  logic             s_ready_q, cs_n_q, sclk_q, mosi_q, busy_q;
`ifdef DAC_SPI_LDAC_EN
  logic             ldac_n_q;
`endif

  logic        tick;
  logic [11:0] data12;
  logic [15:0] frame_w;

  assign tick    = (div_q == DIV_LAST);
  // Left-justify the sample in the 12-bit DAC field.
  assign data12  = 12'(s_data) << PAD;
  assign frame_w = {CFG_BITS, data12};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= 4'd15;
      phase_q   <= 1'b0;
      sreg_q    <= '0;
      s_ready_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DAC_SPI_LDAC_EN
      ldac_n_q  <= 1'b1;
`endif
    end else begin
      if (state_q == IDLE || tick) div_q <= '0;
      else                         div_q <= div_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (s_ready_q && s_valid) begin
            sreg_q    <= frame_w;
            mosi_q    <= frame_w[15];
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            s_ready_q <= 1'b0;
            state_q   <= CS_SETUP;
          end else begin
            s_ready_q <= 1'b1;
          end
        end
        CS_SETUP: begin
          if (tick) begin
            bit_q   <= 4'd15;
            phase_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!phase_q) begin
              sclk_q  <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              // Falling edge: the DAC has sampled this bit, present the next one.
              sclk_q  <= 1'b0;
              phase_q <= 1'b0;
              if (bit_q == 4'd0) begin
                state_q <= CS_HOLD;
              end else begin
                bit_q  <= bit_q - 4'd1;
                sreg_q <= sreg_q << 1;
                mosi_q <= sreg_q[14];
              end
            end
          end
        end
        CS_HOLD: begin
          if (tick) begin
            if (!phase_q) begin
              cs_n_q  <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
`ifdef DAC_SPI_LDAC_EN
              ldac_n_q <= 1'b0;
              state_q  <= LDAC;
`else
              state_q  <= GAP;
`endif
            end
          end
        end
`ifdef DAC_SPI_LDAC_EN
        LDAC: begin
          if (tick) begin
            ldac_n_q <= 1'b1;
            state_q  <= GAP;
          end
        end
`endif
        GAP: begin
          if (tick) begin
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign busy     = busy_q;
`ifdef DAC_SPI_LDAC_EN
  assign dac_ldac_n = ldac_n_q;
`else
  assign dac_ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: decodes SPI frames from the pins and compares with hand-computed words.
module tb_dac_spi_tx;
  localparam int DAC_N   = 10;
  localparam int CLK_DIV = 2;
`ifdef DAC_SPI_LDAC_EN
  localparam int   FRAME_LEN = 37*CLK_DIV + 1;
  localparam logic LDAC_RST  = 1'b1;
`else
  localparam int   FRAME_LEN = 36*CLK_DIV + 1;
  localparam logic LDAC_RST  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DAC_N-1:0] s_data;
  logic             s_valid;
  logic             s_ready, spi_cs_n, spi_sclk, spi_mosi, dac_ldac_n, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  dac_spi_tx #(.DAC_N(DAC_N), .CLK_DIV(CLK_DIV), .CFG_BITS(4'b0111)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .dac_ldac_n(dac_ldac_n), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin-level frame decoder
  logic [15:0] fq[$];
  int          bq[$];
  logic [15:0] mon_word = '0;
  int          mon_bits = 0;
  int          sclk_hi_err = 0;
  logic        sclk_prev = 1'b0, cs_prev = 1'b1, ldac_prev = LDAC_RST;
  int          since_cs = 0, ldac_delay = -1, ldac_acc = 0, ldac_width = -1;

  always @(negedge clk) begin
    if (spi_sclk && !sclk_prev) begin
      if (spi_cs_n) sclk_hi_err++;
      else begin
        mon_word = {mon_word[14:0], spi_mosi};
        mon_bits++;
      end
    end
    if (spi_cs_n && !cs_prev) begin
      fq.push_back(mon_word);
      bq.push_back(mon_bits);
      mon_word = '0;
      mon_bits = 0;
      since_cs = 0;
    end else begin
      since_cs++;
    end
    if (!dac_ldac_n && ldac_prev) ldac_delay = since_cs;
    if (!dac_ldac_n) ldac_acc++;
    if (dac_ldac_n && !ldac_prev) begin
      ldac_width = ldac_acc;
      ldac_acc   = 0;
    end
    sclk_prev = spi_sclk;
    cs_prev   = spi_cs_n;
    ldac_prev = dac_ldac_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [DAC_N-1:0] d, output int t0);
    wait_ready();
    s_data  = d;
    s_valid = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pop_frame(input string tag, input logic [15:0] exp_w, input int exp_b);
    logic [15:0] w;
    int          b;
    if (fq.size() == 0) begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      w = fq.pop_front();
      b = bq.pop_front();
      check(tag, 32'(w), 32'(exp_w));
      check({tag, "_bits"}, 32'(b), 32'(exp_b));
    end
  endtask

  initial begin
    int t0, t1, t2, n, bad;
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 10'h2AA;
    repeat (3) @(negedge clk);
    check("rst_cs_n",  32'(spi_cs_n),   32'd1);
    check("rst_sclk",  32'(spi_sclk),   32'd0);
    check("rst_mosi",  32'(spi_mosi),   32'd0);
    check("rst_ldac",  32'(dac_ldac_n), 32'(LDAC_RST));
    check("rst_ready", 32'(s_ready),    32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1 check("ready_after_rst", 32'(s_ready), 32'd1);

    // Single sample, frame length
    send(10'h2AA, t0);
    n = 0;
    while (!s_ready && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    check("frame_len", 32'(cyc - t0), 32'(FRAME_LEN));
    pop_frame("frame_2aa", 16'h7AA8, 16);
`ifdef DAC_SPI_LDAC_EN
    check("ldac_delay", 32'(ldac_delay), 32'(CLK_DIV));
    check("ldac_width", 32'(ldac_width), 32'(CLK_DIV));
`endif

    // Back-to-back with s_valid held
    wait_ready();
    s_data  = 10'h3FF;
    s_valid = 1'b1;
    @(posedge clk);
    #1 t1 = cyc;
    @(negedge clk);
    s_data = 10'h000;
    wait_ready();
    @(posedge clk);
    #1 t2 = cyc;
    @(negedge clk);
    s_valid = 1'b0;
    check("b2b_interval", 32'(t2 - t1), 32'(FRAME_LEN + 1));
    wait_ready();
    pop_frame("frame_3ff", 16'h7FFC, 16);
    pop_frame("frame_000", 16'h7000, 16);
    check("no_extra_frames", 32'(fq.size()), 32'd0);

    // Input changes after capture are ignored
    send(10'h155, t0);
    s_data = 10'h3FF;
    wait_ready();
    pop_frame("frame_155", 16'h7554, 16);

    // Asynchronous reset during bit 7
    send(10'h2AA, t0);
    n = 0;
    while (mon_bits < 9 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #3 rst_n = 1'b0;
    #1;
    check("abort_cs_n",  32'(spi_cs_n), 32'd1);
    check("abort_sclk",  32'(spi_sclk), 32'd0);
    check("abort_busy",  32'(busy),     32'd0);
    check("abort_ready", 32'(s_ready),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pop_frame("partial", 16'h00F5, 9);
    send(10'h001, t0);
    wait_ready();
    pop_frame("frame_001", 16'h7004, 16);

    // Idle with s_valid low
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0 || busy !== 1'b0 ||
          dac_ldac_n !== LDAC_RST)
        bad++;
    end
    check("idle_static", 32'(bad), 32'd0);
    check("sclk_while_cs_high", 32'(sclk_hi_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Downstream stage of the DDS sine generator: takes each DAC_N-bit sample and serializes it to an external SPI voltage-output DAC (MCP49x1-style 16-bit write frame).
- Owns the SPI timing (CS, SCLK, MOSI) and the optional LDAC latch strobe.
- Applies back-pressure to the sample source through a valid/ready handshake.

Parameters:
- DAC_N, 10, sample width; legal range 8..12.
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range ≥1.
- CFG_BITS, 4'b0111, upper frame nibble: channel A, buffered, 1x gain, active.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- s_data  in  DAC_N  sample from the DDS generator.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  block can accept a sample this cycle.
- spi_cs_n  out  1  DAC chip select, active-low.
- spi_sclk  out  1  SPI clock; idles low (mode 0).
- spi_mosi  out  1  serial data, MSB first.
- dac_ldac_n  out  1  DAC latch strobe, active-low.
- busy  out  1  a frame is in progress (any state other than IDLE).

Behaviour:
- One clock. Reset is asynchronous and active-low.
  - Port names: clk, rst_n.
  - Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, dac_ldac_n=1, s_ready=0, busy=0, state=IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Handshake:
  - A transfer occurs on a clk edge where s_valid && s_ready.
  - s_data is captured into the shift register at that edge and later changes to s_data are ignored.
  - s_ready=1 only in IDLE. It deasserts on the cycle after the transfer edge.
  - s_ready first rises on the first clk edge after rst_n deasserts.
- Frame word (16 bits) = {CFG_BITS, s_data, (12-DAC_N) zero bits}.
  - Example: DAC_N=10, data 10'h2AA gives 16'h7AA8.
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> (LDAC) -> GAP -> IDLE.
  - A divider counter counts 0..CLK_DIV-1; every state step below is timed in half-periods of CLK_DIV clk cycles.
- IDLE: cs_n=1, sclk=0. On a transfer, go to CS_SETUP on the next edge.
- CS_SETUP: cs_n=0, mosi=frame[15], sclk=0. Lasts 1 half-period.
- SHIFT: 16 bits, 2 half-periods each.
  - sclk rises at the start of the second half-period of each bit.
  - sclk falls at the end of the bit; mosi advances to the next bit at that falling edge.
  - A 4-bit bit counter runs 15..0. Leave SHIFT after the falling edge of bit 0.
  - Bit 0 ends with sclk low.
- CS_HOLD: cs_n=0, sclk=0. Lasts 1 half-period. Then cs_n=1.
- LDAC (macro only): cs_n=1, dac_ldac_n=0 for 1 half-period. Then dac_ldac_n=1.
- GAP: cs_n=1 for 1 half-period, to meet the minimum CS-high time. Then IDLE; mosi returns to 0.
- Frame length, transfer edge to the next s_ready=1:
  - Without the macro: 36*CLK_DIV + 1 cycles.
  - With the macro: 37*CLK_DIV + 1 cycles.
- sclk never toggles while cs_n=1. Exactly 16 rising sclk edges per frame.
- s_valid held continuously: frames run back-to-back with only the single IDLE cycle between them. No sample is dropped and no sample is duplicated.
- s_valid deasserted: the block stays in IDLE with all outputs static.
- rst_n asserted mid-frame: all outputs go to their reset values immediately (asynchronously) and the partial frame is abandoned. After release, the next frame starts cleanly from IDLE.
- CLK_DIV=1 is legal: sclk = clk/2.

Optional Feature:
- Macro: DAC_SPI_LDAC_EN.
- Defined: the LDAC state is included and dac_ldac_n pulses low for CLK_DIV cycles after each frame, so the output update is synchronised to frame completion.
- Undefined: the LDAC state is removed, dac_ldac_n is tied to 0 (DAC updates on the CS rising edge), and the frame is CLK_DIV cycles shorter.

Test Plan:
- Reset: hold rst_n=0 with s_valid=1 -> cs_n=1, sclk=0, mosi=0, ldac_n=1, s_ready=0. s_ready=1 one edge after release.
- CLK_DIV=2, single sample 10'h2AA -> 16 sclk rises while cs_n=0; mosi sampled on the rises = 16'h7AA8; s_ready returns after 73 cycles (macro off).
- CLK_DIV=2, s_valid held, samples 10'h3FF then 10'h000 -> frames 16'h7FFC then 16'h7000 back-to-back; both frames complete, no sample skipped.
- Change s_data mid-frame: 10'h155 captured, then s_data forced to 10'h3FF -> frame is 16'h7554.
- rst_n pulsed low during bit 7 -> cs_n=1 asynchronously. The next sample 10'h001 then sends 16'h7004 cleanly.
- DAC_SPI_LDAC_EN defined, CLK_DIV=4 -> ldac_n low for exactly 4 cycles, starting 4 cycles after cs_n rises; frame length 149 cycles.
